// File: rtl/reg_file_pkg.sv
// Shared CPU definitions for the register file: register count and address width.
package reg_file_pkg;

  localparam int REG_ADDR_WIDTH = 4;
  localparam int REG_COUNT      = 16;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: write, reserve and two independent read ports.
interface reg_file_if #(
  parameter int BUS_WIDTH = 8
);
  import reg_file_pkg::*;

  logic                 wr_en;
  reg_addr_t            wr_addr;
  logic [BUS_WIDTH-1:0] wr_data;
  logic                 rsv_en;
  reg_addr_t            rsv_addr;
  reg_addr_t            rd_addr_a;
  reg_addr_t            rd_addr_b;
  logic [BUS_WIDTH-1:0] rd_data_a;
  logic [BUS_WIDTH-1:0] rd_data_b;
  logic                 rd_busy_a;
  logic                 rd_busy_b;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b
  );

endinterface

// File: rtl/reg_file_mux16.sv
// Generic 16-input selector shared by the register file read ports.
module mux16
  import reg_file_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] i_in [REG_COUNT],
  input  reg_addr_t            i_sel,
  output logic [BUS_WIDTH-1:0] o_out
);

  assign o_out = i_in[i_sel];

endmodule

// File: rtl/reg_file.sv
// 16-entry register file with per-register pending bits, two combinational
// read ports, optional write-to-read bypass and optional hardwired-zero r0.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int ZERO_R0   = 1,
  parameter int BYPASS    = 1
) (
  input logic       clk,
  input logic       reset,
  reg_file_if.slave bus
);

  logic [BUS_WIDTH-1:0] r_mem  [REG_COUNT];
  logic [0:0]           r_pend [REG_COUNT];

  logic                 w_wr_ok;
  logic                 w_rsv_ok;
  logic [BUS_WIDTH-1:0] w_mux_data_a;
  logic [BUS_WIDTH-1:0] w_mux_data_b;
  logic [0:0]           w_mux_busy_a;
  logic [0:0]           w_mux_busy_b;

  function automatic logic f_is_r0(input reg_addr_t addr);
    return (ZERO_R0 != 0) && (addr == '0);
  endfunction

  // Post-mux read resolution: bypass first, then zero-register and reset override.
  function automatic logic [BUS_WIDTH:0] f_resolve(
    input reg_addr_t            addr,
    input logic [BUS_WIDTH-1:0] mux_data,
    input logic                 mux_busy,
    input logic                 rst,
    input logic                 wr_ok,
    input reg_addr_t            wr_addr,
    input logic [BUS_WIDTH-1:0] wr_data
  );
    logic [BUS_WIDTH:0] v;
    v = {mux_busy, mux_data};
    if ((BYPASS != 0) && wr_ok && (addr == wr_addr)) begin
      v = {1'b0, wr_data};
    end
    if (rst || f_is_r0(addr)) begin
      v = '0;
    end
    return v;
  endfunction

  assign w_wr_ok  = bus.wr_en  && !f_is_r0(bus.wr_addr);
  assign w_rsv_ok = bus.rsv_en && !f_is_r0(bus.rsv_addr);

  // Reserve is applied after write so a same-register collision leaves it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i]  <= '0;
        r_pend[i] <= 1'b0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wr_addr]  <= bus.wr_data;
        r_pend[bus.wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_pend[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  mux16 #(.BUS_WIDTH(BUS_WIDTH)) u_data_a (
    .i_in  (r_mem),
    .i_sel (bus.rd_addr_a),
    .o_out (w_mux_data_a)
  );

  mux16 #(.BUS_WIDTH(1)) u_busy_a (
    .i_in  (r_pend),
    .i_sel (bus.rd_addr_a),
    .o_out (w_mux_busy_a)
  );

  mux16 #(.BUS_WIDTH(BUS_WIDTH)) u_data_b (
    .i_in  (r_mem),
    .i_sel (bus.rd_addr_b),
    .o_out (w_mux_data_b)
  );

  mux16 #(.BUS_WIDTH(1)) u_busy_b (
    .i_in  (r_pend),
    .i_sel (bus.rd_addr_b),
    .o_out (w_mux_busy_b)
  );

  assign {bus.rd_busy_a, bus.rd_data_a} = f_resolve(bus.rd_addr_a, w_mux_data_a, w_mux_busy_a[0],
                                                    reset, w_wr_ok, bus.wr_addr, bus.wr_data);
  assign {bus.rd_busy_b, bus.rd_data_b} = f_resolve(bus.rd_addr_b, w_mux_data_b, w_mux_busy_b[0],
                                                    reset, w_wr_ok, bus.wr_addr, bus.wr_data);

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (zero-r0+bypass, and neither) driven in
// lockstep and compared against an array model every cycle.
module tb_reg_file;
  import reg_file_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rsv_en;
  logic [3:0] wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model state; index 0 = ZERO_R0=1/BYPASS=1 instance, index 1 = ZERO_R0=0/BYPASS=0.
  logic [7:0] m_mem  [2][16];
  bit         m_pend [2][16];

  reg_file_if #(.BUS_WIDTH(8)) bus1 ();
  reg_file_if #(.BUS_WIDTH(8)) bus0 ();

  assign bus1.wr_en = wr_en;   assign bus0.wr_en = wr_en;
  assign bus1.wr_addr = wr_addr; assign bus0.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data; assign bus0.wr_data = wr_data;
  assign bus1.rsv_en = rsv_en; assign bus0.rsv_en = rsv_en;
  assign bus1.rsv_addr = rsv_addr; assign bus0.rsv_addr = rsv_addr;
  assign bus1.rd_addr_a = rd_addr_a; assign bus0.rd_addr_a = rd_addr_a;
  assign bus1.rd_addr_b = rd_addr_b; assign bus0.rd_addr_b = rd_addr_b;

  reg_file #(.BUS_WIDTH(8), .ZERO_R0(1), .BYPASS(1)) u_dut_on (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  reg_file #(.BUS_WIDTH(8), .ZERO_R0(0), .BYPASS(0)) u_dut_off (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 16; i++) begin
          m_mem[c][i]  <= 8'h00;
          m_pend[c][i] <= 1'b0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (wr_en && !(c == 0 && wr_addr == 4'd0)) begin
          m_mem[c][wr_addr]  <= wr_data;
          m_pend[c][wr_addr] <= 1'b0;
        end
        if (rsv_en && !(c == 0 && rsv_addr == 4'd0))
          m_pend[c][rsv_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [8:0] exp_rd(int c, logic [3:0] a);
    if (reset) return 9'h000;
    if (c == 0 && a == 4'd0) return 9'h000;
    if (c == 0 && wr_en && wr_addr == a) return {1'b0, wr_data};
    return {m_pend[c][a], m_mem[c][a]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("on_a",  {23'd0, bus1.rd_busy_a, bus1.rd_data_a}, {23'd0, exp_rd(0, rd_addr_a)});
      check("on_b",  {23'd0, bus1.rd_busy_b, bus1.rd_data_b}, {23'd0, exp_rd(0, rd_addr_b)});
      check("off_a", {23'd0, bus0.rd_busy_a, bus0.rd_data_a}, {23'd0, exp_rd(1, rd_addr_a)});
      check("off_b", {23'd0, bus0.rd_busy_b, bus0.rd_data_b}, {23'd0, exp_rd(1, rd_addr_b)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_zero(string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(15 - a);
      #1;
      check({tag, "_on"},  {bus1.rd_busy_a, bus1.rd_data_a, bus1.rd_busy_b, bus1.rd_data_b}, 32'd0);
      check({tag, "_off"}, {bus0.rd_busy_a, bus0.rd_data_a, bus0.rd_busy_b, bus0.rd_data_b}, 32'd0);
    end
  endtask

  function automatic logic [3:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 4'd3;
      1: return 4'd12;
      2: return 4'd9;
      3: return 4'd0;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = 4'd0; rsv_addr = 4'd0; wr_data = 8'h00;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    chk_en = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    sweep_zero("init_zero");

    // Write r5 with same-cycle read, then registered read.
    step();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    #1;
    check("byp_on_r5",  bus1.rd_data_a, 32'h3C);
    check("byp_off_r5", bus0.rd_data_a, 32'h00);
    step();
    wr_en = 1'b0;
    #1;
    check("rd_on_r5",  bus1.rd_data_a, 32'h3C);
    check("rd_off_r5", bus0.rd_data_b, 32'h3C);

    // Reserve / write / collision on r7.
    step();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    rsv_en = 1'b0; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    check("rsv_busy_on",  bus1.rd_busy_a, 32'd1);
    check("rsv_busy_off", bus0.rd_busy_b, 32'd1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
    #1;
    check("byp_on_r7",  {bus1.rd_busy_a, bus1.rd_data_a}, 32'h011);
    check("byp_off_r7", {bus0.rd_busy_a, bus0.rd_data_a}, 32'h100);
    step();
    wr_en = 1'b0;
    #1;
    check("wr_r7_on",  {bus1.rd_busy_a, bus1.rd_data_a}, 32'h011);
    check("wr_r7_off", {bus0.rd_busy_b, bus0.rd_data_b}, 32'h011);
    wr_en = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    check("wrsv_r7_on",  {bus1.rd_busy_a, bus1.rd_data_a}, 32'h111);
    check("wrsv_r7_off", {bus0.rd_busy_a, bus0.rd_data_a}, 32'h111);

    // Register 0 write + reserve.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    #1;
    check("r0_byp_on", {bus1.rd_busy_a, bus1.rd_data_a}, 32'h000);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    check("r0_on",  {bus1.rd_busy_b, bus1.rd_data_b}, 32'h000);
    check("r0_off", {bus0.rd_busy_a, bus0.rd_data_a}, 32'h1FF);

    // Load r1..r15, then reset between edges.
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i * 17);
      step();
    end
    wr_en = 1'b0; rd_addr_a = 4'd15; rd_addr_b = 4'd12;
    #1;
    check("r15_loaded", bus1.rd_data_a, 32'hFF);
    check("r12_loaded", bus0.rd_data_b, 32'hCC);
    reset = 1'b1;
    #1;
    check("async_rst_on",  {bus1.rd_busy_a, bus1.rd_data_a, bus1.rd_busy_b, bus1.rd_data_b}, 32'd0);
    check("async_rst_off", {bus0.rd_busy_a, bus0.rd_data_a, bus0.rd_busy_b, bus0.rd_data_b}, 32'd0);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'hA5;
    #1;
    check("rst_no_byp", bus1.rd_data_a | {24'd0, bus1.rd_data_b}, 32'd0);
    step();
    wr_en = 1'b0;
    sweep_zero("rst_zero");

    // Release reset mid-cycle; the next edge must accept a write.
    step();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h5A; rd_addr_a = 4'd4; rd_addr_b = 4'd6;
    step();
    wr_en = 1'b0;
    #1;
    check("post_rst_wr", bus0.rd_data_a, 32'h5A);
    check("rst_dropped_wr", bus0.rd_data_b, 32'h00);

    // Randomized traffic on ports A/B at (3,12), shared 9, or random addresses.
    for (int n = 0; n < 1200; n++) begin
      step();
      if (reset) reset = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin rd_addr_a = 4'd3; rd_addr_b = 4'd12; end
        6, 7:             begin rd_addr_a = 4'd9; rd_addr_b = 4'd9;  end
        default: begin
          rd_addr_a = 4'($urandom_range(0, 15));
          rd_addr_b = 4'($urandom_range(0, 15));
        end
      endcase
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = pick_addr();
      wr_data  = 8'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = pick_addr();
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
    end

    step();
    reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
